// File: rtl/cc_frame_feeder.sv
// Zero-pad frame feeder: buffers DEPTH samples per channel, then emits one FFT config word and one
// 2*DEPTH-beat lead/trail zero-padded AXI-Stream frame to NCH FFT cores in lockstep.
module cc_frame_feeder #(
    parameter int          NCH      = 2,
    parameter int          SAMPLE_W = 10,
    parameter int          DEPTH    = 128,
    parameter logic [23:0] CFG_WORD = 24'h00AAAD,
    parameter bit          SIGN_EXT = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_b,
    input  logic                    wr_en,
    input  logic [NCH*SAMPLE_W-1:0] wr_data,
    output logic                    full,
    input  logic                    start,
    input  logic [NCH-1:0]          pad_lead,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf,
    output logic                    sync_err,
    output logic [23:0]             m_cfg_tdata,
    output logic                    m_cfg_tvalid,
    input  logic [NCH-1:0]          m_cfg_tready,
    output logic [NCH*32-1:0]       m_data_tdata,
    output logic                    m_data_tvalid,
    input  logic [NCH-1:0]          m_data_tready,
    output logic                    m_data_tlast
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int N  = 2 * DEPTH;
    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
    localparam logic [AW:0] PTR_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_BEAT = (AW+1)'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_CFG, S_STREAM} state_t;

    state_t                    state_q, state_d;
    logic [1:0]                rst_sync_q;
    logic                      rst_n;
    logic [AW:0]               wptr_q;
    logic [AW:0]               beat_q;
    logic [NCH-1:0]            pad_q;
    logic                      dvalid_q;
    logic [NCH*32-1:0]         tdata_q;
    logic                      tlast_q;
    logic                      done_q;
    logic                      ovf_q;
    logic                      sync_err_q;
    logic [NCH*SAMPLE_W-1:0]   mem [DEPTH];
    logic [NCH*SAMPLE_W-1:0]   rdata_q;
    logic [AW-1:0]             raddr;

    logic wr_accept, wr_drop, start_ok, cfg_accept, data_accept, last_accept;
    logic cfg_mixed, data_mixed;

    function automatic logic [15:0] ext16(input logic [SAMPLE_W-1:0] s);
        logic signed [SAMPLE_W-1:0] ss;
        ss = signed'(s);
        if (SIGN_EXT) return 16'(ss);
        else          return 16'(s);
    endfunction

    // A channel carries data in the half that matches its pad_lead bit, zeros in the other.
    function automatic logic [NCH*32-1:0] make_beat(input logic [NCH*SAMPLE_W-1:0] smp,
                                                    input logic                    upper,
                                                    input logic [NCH-1:0]          lead);
        logic [NCH*32-1:0] w;
        w = '0;
        for (int c = 0; c < NCH; c++) begin
            if (lead[c] == upper) w[c*32 +: 16] = ext16(smp[c*SAMPLE_W +: SAMPLE_W]);
        end
        return w;
    endfunction

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign full        = (wptr_q == PTR_FULL);
    assign wr_accept   = (state_q == S_IDLE) && wr_en && !full;
    assign wr_drop     = wr_en && (full || busy);
    assign start_ok    = (state_q == S_IDLE) && start && full;
    assign cfg_accept  = (state_q == S_CFG) && (&m_cfg_tready);
    assign data_accept = (state_q == S_STREAM) && dvalid_q && (&m_data_tready);
    assign last_accept = data_accept && (beat_q == LAST_BEAT);
    assign cfg_mixed   = (state_q == S_CFG) && (|m_cfg_tready) && !(&m_cfg_tready);
    assign data_mixed  = (state_q == S_STREAM) && dvalid_q && (|m_data_tready) && !(&m_data_tready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_ok)    state_d = S_CFG;
            S_CFG:    if (cfg_accept)  state_d = S_STREAM;
            S_STREAM: if (last_accept) state_d = S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q != S_IDLE);
        m_cfg_tvalid = (state_q == S_CFG);
    end

    // Prefetch: rdata_q always holds the sample the next beat needs when the current one is accepted.
    always_comb begin
        raddr = '0;
        if (cfg_accept)
            raddr = AW'(1);
        else if (state_q == S_STREAM)
            raddr = beat_q[AW-1:0] + (data_accept ? AW'(2) : AW'(1));
    end

    always_ff @(posedge clk) begin
        if (wr_accept) mem[wptr_q[AW-1:0]] <= wr_data;
        rdata_q <= mem[raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            beat_q     <= '0;
            pad_q      <= '0;
            dvalid_q   <= 1'b0;
            tdata_q    <= '0;
            tlast_q    <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            done_q <= last_accept;
            if (wr_drop)                 ovf_q      <= 1'b1;
            if (cfg_mixed || data_mixed) sync_err_q <= 1'b1;
            if (wr_accept)        wptr_q <= wptr_q + PTR_ONE;
            else if (last_accept) wptr_q <= '0;
            if (start_ok) pad_q <= pad_lead;
            if (cfg_accept) begin
                dvalid_q <= 1'b1;
                beat_q   <= '0;
                tdata_q  <= make_beat(rdata_q, 1'b0, pad_q);
                tlast_q  <= 1'b0;
            end else if (last_accept) begin
                dvalid_q <= 1'b0;
                tdata_q  <= '0;
                tlast_q  <= 1'b0;
            end else if (data_accept) begin
                beat_q   <= beat_q + PTR_ONE;
                tdata_q  <= make_beat(rdata_q, (beat_q + PTR_ONE) >= PTR_FULL, pad_q);
                tlast_q  <= ((beat_q + PTR_ONE) == LAST_BEAT);
            end
        end
    end

    assign done          = done_q;
    assign ovf           = ovf_q;
    assign sync_err      = sync_err_q;
    assign m_cfg_tdata   = CFG_WORD;
    assign m_data_tdata  = tdata_q;
    assign m_data_tvalid = dvalid_q;
    assign m_data_tlast  = tlast_q;

endmodule

// File: tb/tb_cc_frame_feeder.sv
// Directed bench for cc_frame_feeder: fill, config skew, backpressure, dropped writes, mid-frame reset, zero-extend.
module tb_cc_frame_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_b;

    logic        wr_en, start, full, busy, done, ovf, sync_err;
    logic [19:0] wr_data;
    logic [1:0]  pad_lead, cfg_tready, d_tready;
    logic [23:0] cfg_tdata;
    logic        cfg_tvalid, d_tvalid, d_tlast;
    logic [63:0] d_tdata;

    logic         b_wr_en, b_start, b_full, b_busy, b_done, b_ovf, b_sync_err;
    logic [39:0]  b_wr_data;
    logic [3:0]   b_pad_lead, b_cfg_tready, b_d_tready;
    logic [23:0]  b_cfg_tdata;
    logic         b_cfg_tvalid, b_d_tvalid, b_d_tlast;
    logic [127:0] b_d_tdata;

    cc_frame_feeder dut (
        .clk(clk), .reset_b(reset_b), .wr_en(wr_en), .wr_data(wr_data), .full(full),
        .start(start), .pad_lead(pad_lead), .busy(busy), .done(done), .ovf(ovf),
        .sync_err(sync_err), .m_cfg_tdata(cfg_tdata), .m_cfg_tvalid(cfg_tvalid),
        .m_cfg_tready(cfg_tready), .m_data_tdata(d_tdata), .m_data_tvalid(d_tvalid),
        .m_data_tready(d_tready), .m_data_tlast(d_tlast)
    );

    cc_frame_feeder #(.NCH(4), .SAMPLE_W(10), .DEPTH(4), .SIGN_EXT(1'b0)) dut_b (
        .clk(clk), .reset_b(reset_b), .wr_en(b_wr_en), .wr_data(b_wr_data), .full(b_full),
        .start(b_start), .pad_lead(b_pad_lead), .busy(b_busy), .done(b_done), .ovf(b_ovf),
        .sync_err(b_sync_err), .m_cfg_tdata(b_cfg_tdata), .m_cfg_tvalid(b_cfg_tvalid),
        .m_cfg_tready(b_cfg_tready), .m_data_tdata(b_d_tdata), .m_data_tvalid(b_d_tvalid),
        .m_data_tready(b_d_tready), .m_data_tlast(b_d_tlast)
    );

    int errors = 0;
    int checks = 0;
    logic [9:0] s0 [128];
    logic [9:0] s1 [128];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] exp_beat(input int k, input logic [1:0] lead);
        logic [15:0] r0, r1;
        int idx;
        idx = k % 128;
        r0 = (lead[0] ? (k < 128) : (k >= 128)) ? 16'h0000 : {{6{s0[idx][9]}}, s0[idx]};
        r1 = (lead[1] ? (k < 128) : (k >= 128)) ? 16'h0000 : {{6{s1[idx][9]}}, s1[idx]};
        return {16'h0000, r1, 16'h0000, r0};
    endfunction

    initial begin
        int cnt, cyc, stall, gaps;
        logic [63:0] held;
        reset_b = 1'b0; wr_en = 1'b0; wr_data = '0; start = 1'b0; pad_lead = '0;
        cfg_tready = '0; d_tready = '0;
        b_wr_en = 1'b0; b_wr_data = '0; b_start = 1'b0; b_pad_lead = '0;
        b_cfg_tready = '0; b_d_tready = '0;
        repeat (3) tick();

        // Reset state
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_sync_err", 64'(sync_err), 64'd0);
        chk("rst_cfg_tvalid", 64'(cfg_tvalid), 64'd0);
        chk("rst_d_tvalid", 64'(d_tvalid), 64'd0);
        chk("rst_d_tlast", 64'(d_tlast), 64'd0);
        chk("rst_d_tdata", d_tdata, 64'd0);
        chk("rst_cfg_tdata", 64'(cfg_tdata), 64'h00AAAD);
        reset_b = 1'b1;
        repeat (4) tick();

        // 100 samples, start must be ignored
        for (int i = 0; i < 100; i++) begin
            wr_en = 1'b1; wr_data = {10'h3FF, 10'(i)}; s0[i] = 10'(i); s1[i] = 10'h3FF;
            tick();
        end
        wr_en = 1'b0; start = 1'b1; pad_lead = 2'b01;
        tick();
        start = 1'b0;
        chk("start_partial_busy", 64'(busy), 64'd0);
        chk("start_partial_full", 64'(full), 64'd0);
        tick();
        chk("start_partial_cfg_tvalid", 64'(cfg_tvalid), 64'd0);
        for (int i = 100; i < 128; i++) begin
            wr_en = 1'b1; wr_data = {10'h3FF, 10'(i)}; s0[i] = 10'(i); s1[i] = 10'h3FF;
            tick();
        end
        wr_en = 1'b0;
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_ovf", 64'(ovf), 64'd0);

        // 129th write is dropped
        wr_en = 1'b1; wr_data = {10'h111, 10'h222};
        tick();
        wr_en = 1'b0;
        chk("drop_ovf", 64'(ovf), 64'd1);
        chk("drop_full", 64'(full), 64'd1);

        // Frame 1: config ready skew, then backpressure at beat 50
        pad_lead = 2'b01; start = 1'b1;
        tick();
        start = 1'b0; pad_lead = 2'b10;
        for (int c = 1; c <= 5; c++) begin
            cfg_tready = (c >= 5) ? 2'b11 : ((c >= 3) ? 2'b01 : 2'b00);
            chk($sformatf("cfg_tvalid_c%0d", c), 64'(cfg_tvalid), 64'd1);
            tick();
        end
        cfg_tready = 2'b00;
        chk("cfg_done_tvalid", 64'(cfg_tvalid), 64'd0);
        chk("cfg_sync_err", 64'(sync_err), 64'd1);
        chk("cfg_d_tvalid_beat0", 64'(d_tvalid), 64'd1);
        cnt = 0; cyc = 0; stall = 0; held = '0;
        while (cnt < 256 && cyc < 600) begin
            if (cnt == 50 && stall < 4) begin
                d_tready = 2'b00;
                if (stall == 0) held = d_tdata;
                else chk($sformatf("bp_hold_%0d", stall), d_tdata, held);
                chk($sformatf("bp_valid_%0d", stall), 64'(d_tvalid), 64'd1);
                stall++;
            end else begin
                d_tready = 2'b11;
                if (d_tvalid) begin
                    chk($sformatf("f1_beat%0d", cnt), d_tdata, exp_beat(cnt, 2'b01));
                    chk($sformatf("f1_tlast%0d", cnt), 64'(d_tlast), 64'(cnt == 255));
                    cnt++;
                end
            end
            tick();
            cyc++;
        end
        chk("f1_count", 64'(cnt), 64'd256);
        chk("f1_done", 64'(done), 64'd1);
        chk("f1_busy_after", 64'(busy), 64'd0);
        chk("f1_full_after", 64'(full), 64'd0);
        chk("f1_tvalid_after", 64'(d_tvalid), 64'd0);
        // Write during the done cycle becomes sample 0 of the next buffer
        wr_en = 1'b1; wr_data = {10'h155, 10'd300}; s0[0] = 10'd300; s1[0] = 10'h155;
        tick();
        wr_en = 1'b0;
        chk("f1_done_pulse", 64'(done), 64'd0);

        // Frame 2: reset at beat 77
        for (int i = 1; i < 128; i++) begin
            wr_en = 1'b1; wr_data = {10'h155, 10'(300 + i)}; s0[i] = 10'(300 + i); s1[i] = 10'h155;
            tick();
        end
        wr_en = 1'b0;
        chk("f2_full", 64'(full), 64'd1);
        pad_lead = 2'b10; cfg_tready = 2'b11; d_tready = 2'b11; start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0; cyc = 0;
        while (cnt < 77 && cyc < 200) begin
            if (d_tvalid) begin
                chk($sformatf("f2_beat%0d", cnt), d_tdata, exp_beat(cnt, 2'b10));
                cnt++;
            end
            tick();
            cyc++;
        end
        chk("f2_count", 64'(cnt), 64'd77);
        chk("f2_beat77_valid", 64'(d_tvalid), 64'd1);
        reset_b = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_full", 64'(full), 64'd0);
        chk("mid_rst_tvalid", 64'(d_tvalid), 64'd0);
        chk("mid_rst_tdata", d_tdata, 64'd0);
        chk("mid_rst_tlast", 64'(d_tlast), 64'd0);
        chk("mid_rst_cfg_tvalid", 64'(cfg_tvalid), 64'd0);
        chk("mid_rst_ovf", 64'(ovf), 64'd0);
        chk("mid_rst_sync_err", 64'(sync_err), 64'd0);
        repeat (2) tick();
        reset_b = 1'b1;
        repeat (4) tick();

        // Frame 3: clean fill, readies tied high, back-to-back
        for (int i = 0; i < 128; i++) begin
            wr_en = 1'b1; wr_data = {10'h3FF, 10'(i)}; s0[i] = 10'(i); s1[i] = 10'h3FF;
            tick();
        end
        wr_en = 1'b0;
        pad_lead = 2'b01; start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0; cyc = 0; gaps = 0;
        while (cnt < 256 && cyc < 400) begin
            if (d_tvalid) begin
                chk($sformatf("f3_beat%0d", cnt), d_tdata, exp_beat(cnt, 2'b01));
                chk($sformatf("f3_tlast%0d", cnt), 64'(d_tlast), 64'(cnt == 255));
                cnt++;
            end else if (cnt > 0) begin
                gaps++;
            end
            tick();
            cyc++;
        end
        chk("f3_count", 64'(cnt), 64'd256);
        chk("f3_gaps", 64'(gaps), 64'd0);
        chk("f3_done", 64'(done), 64'd1);
        chk("f3_busy_after", 64'(busy), 64'd0);
        chk("f3_sync_err", 64'(sync_err), 64'd0);
        tick();
        chk("f3_done_pulse", 64'(done), 64'd0);

        // Zero-extend, 4 channels
        for (int i = 0; i < 4; i++) begin
            b_wr_en = 1'b1; b_wr_data = {4{10'h200}};
            tick();
        end
        b_wr_en = 1'b0;
        chk("b_full", 64'(b_full), 64'd1);
        b_pad_lead = 4'b0000; b_cfg_tready = 4'hF; b_d_tready = 4'hF; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        cnt = 0; cyc = 0;
        while (cnt < 8 && cyc < 50) begin
            if (b_d_tvalid) begin
                for (int c = 0; c < 4; c++) begin
                    if (cnt == 0)
                        chk($sformatf("b_beat0_ch%0d", c), 64'(b_d_tdata[c*32 +: 32]), 64'h0000_0200);
                    if (cnt == 4)
                        chk($sformatf("b_beat4_ch%0d", c), 64'(b_d_tdata[c*32 +: 32]), 64'h0);
                end
                cnt++;
            end
            tick();
            cyc++;
        end
        chk("b_count", 64'(cnt), 64'd8);
        chk("b_done", 64'(b_done), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
